// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the canonical NOP and
// the fetch alignment granularity.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } ifetch_state_t;

  localparam logic [31:0] INSTR_NOP         = 32'h0000_0013;
  localparam int          IFETCH_ALIGN_BITS = 2;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
// master = fetch stage, slave = memory plus decode.
interface instruction_fetch_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output if_valid, if_instr, if_pc, if_fault,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  if_valid, if_instr, if_pc, if_fault,
    output if_ready
  );

endinterface

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: one-entry holding register for the instruction, its PC and
// fault flag presented to decode. PC and instruction load at different times.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_load_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               instr_load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               fault_i,
  input  logic               clear_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               fault_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               fault_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_W'(INSTR_NOP);
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      if (pc_load_i) pc_q <= pc_i;
      if (instr_load_i) begin
        instr_q <= instr_i;
        fault_q <= fault_i;
      end
      // A load always wins over a clear; the FSM never requests both at once.
      if (instr_load_i)  valid_q <= 1'b1;
      else if (clear_i)  valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, one-entry output buffer to decode.
// Optional misaligned-PC trap enabled by defining IFETCH_MISALIGN_CHECK_EN.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_advance,
  input  logic              flush,
  instruction_fetch_if.master bus
);

  ifetch_state_t state_q;
  logic          req_valid_q;
  logic          drop_q;

  logic misaligned;
  logic take_misalign;
  logic req_fire;
  logic resp_take;
  logic buf_clear;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misaligned = (state_q == REQ) && (pc[IFETCH_ALIGN_BITS-1:0] != '0);
`else
  assign misaligned = 1'b0;
`endif

  // A redirect in the detecting cycle keeps us in REQ on the new PC instead.
  assign take_misalign = misaligned & ~flush;

  assign bus.imem_req_valid = req_valid_q & ~misaligned;
  assign bus.imem_req_addr  = (state_q == REQ)
                              ? {pc[ADDR_W-1:IFETCH_ALIGN_BITS], {IFETCH_ALIGN_BITS{1'b0}}}
                              : '0;

  assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
  assign resp_take = (state_q == WAIT) & bus.imem_resp_valid & ~drop_q & ~flush;
  assign buf_clear = (state_q == FULL) & (flush | bus.if_ready);

  assign pc_advance = resp_take | take_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= REQ;
          req_valid_q <= 1'b1;
        end
        REQ: begin
          if (take_misalign) begin
            state_q     <= FULL;
            req_valid_q <= 1'b0;
          end else if (req_fire) begin
            // An accepted request is outstanding even if flushed this cycle.
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
            drop_q      <= flush;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            if (drop_q | flush) begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              drop_q      <= 1'b0;
            end else begin
              state_q <= FULL;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        FULL: begin
          if (flush | bus.if_ready) begin
            state_q     <= REQ;
            req_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
          drop_q      <= 1'b0;
        end
      endcase
    end
  end

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .pc_load_i    (req_fire | take_misalign),
    .pc_i         (pc),
    .instr_load_i (resp_take | take_misalign),
    .instr_i      (take_misalign ? INSTR_W'(INSTR_NOP) : bus.imem_resp_data),
    .fault_i      (take_misalign),
    .clear_i      (buf_clear),
    .valid_o      (bus.if_valid),
    .instr_o      (bus.if_instr),
    .pc_o         (bus.if_pc),
    .fault_o      (bus.if_fault)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table-driven fetch transactions
// with a scoreboard queue, plus hand-written flush/reset/misalign sequences.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        pc_advance;
  logic        flush;

  instruction_fetch_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

  instruction_fetch #(.ADDR_W(64), .INSTR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_advance (pc_advance),
    .flush      (flush),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    int          req_wait;
    int          resp_wait;
    int          ready_wait;
    logic [31:0] data;
    logic [63:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        fault;
  } exp_t;

`ifdef IFETCH_MISALIGN_CHECK_EN
  localparam int NV = 5;
`else
  localparam int NV = 6;
`endif

  vec_t vecs[NV];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_valid"}, bus.imem_req_valid, 0);
    check({tag, " req_addr"},  bus.imem_req_addr,  0);
    check({tag, " pc_advance"}, pc_advance,        0);
    check({tag, " if_valid"},  bus.if_valid,       0);
    check({tag, " if_instr"},  bus.if_instr,       64'h13);
    check({tag, " if_pc"},     bus.if_pc,          0);
    check({tag, " if_fault"},  bus.if_fault,       0);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: output valid with empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " if_instr"}, bus.if_instr, e.instr);
      check({tag, " if_pc"},    bus.if_pc,    e.pc);
      check({tag, " if_fault"}, bus.if_fault, e.fault);
    end
  endtask

  // Entered with the FSM in REQ (or about to be); leaves it in REQ.
  task automatic do_fetch(input vec_t v);
    exp_t e;
    int   n = 0;
    pc = v.pc; flush = 0; bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.if_ready = 0;
    #1;
    while (!bus.imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check("req_valid", bus.imem_req_valid, 1);
    check("req_addr", bus.imem_req_addr, v.exp_addr);
    for (int i = 0; i < v.req_wait; i++) begin
      check("stall req_valid", bus.imem_req_valid, 1);
      check("stall req_addr", bus.imem_req_addr, v.exp_addr);
      check("stall pc_advance", pc_advance, 0);
      tick();
    end
    bus.imem_req_ready = 1;
    #1;
    check("accept pc_advance", pc_advance, 0);
    tick();
    bus.imem_req_ready = 0;
    #1;
    for (int i = 0; i < v.resp_wait; i++) begin
      check("wait pc_advance", pc_advance, 0);
      check("wait req_valid", bus.imem_req_valid, 0);
      check("wait if_valid", bus.if_valid, 0);
      tick();
    end
    bus.imem_resp_valid = 1;
    bus.imem_resp_data  = v.data;
    e.instr = v.data; e.pc = v.pc; e.fault = 0;
    sb.push_back(e);
    #1;
    check("resp pc_advance", pc_advance, 1);
    tick();
    bus.imem_resp_valid = 0;
    bus.imem_resp_data  = 32'h0;
    #1;
    check("full if_valid", bus.if_valid, 1);
    check("full pc_advance", pc_advance, 0);
    check("full req_valid", bus.imem_req_valid, 0);
    pop_compare("full");
    for (int i = 0; i < v.ready_wait; i++) begin
      tick();
      check("hold if_valid", bus.if_valid, 1);
      check("hold if_instr", bus.if_instr, v.data);
      check("hold if_pc", bus.if_pc, v.pc);
      check("hold req_valid", bus.imem_req_valid, 0);
    end
    bus.if_ready = 1;
    tick();
    bus.if_ready = 0;
    #1;
    check("drain if_valid", bus.if_valid, 0);
    check("drain req_valid", bus.imem_req_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{64'h0,    0, 0, 0, 32'h0050_0093, 64'h0};
    vecs[1] = '{64'h100,  4, 0, 0, 32'h0010_8113, 64'h100};
    vecs[2] = '{64'h104,  0, 2, 5, 32'h0020_81b3, 64'h104};
    vecs[3] = '{64'h2000, 1, 3, 1, 32'hfe00_0ee3, 64'h2000};
    vecs[4] = '{64'hffff_ffff_ffff_fffc, 0, 0, 0, 32'h1234_5678, 64'hffff_ffff_ffff_fffc};
`ifndef IFETCH_MISALIGN_CHECK_EN
    vecs[5] = '{64'h106,  0, 0, 0, 32'hcafe_f00d, 64'h104};
`endif

    rst = 1; pc = 0; flush = 0;
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0; bus.if_ready = 0;
    tick();
    tick();
    check_reset_outputs("reset");

    // Cycle 0 after release is IDLE; the first request appears in cycle 1.
    rst = 0;
    #1;
    check("idle req_valid", bus.imem_req_valid, 0);
    tick();
    check("cycle1 req_valid", bus.imem_req_valid, 1);

    for (int i = 0; i < NV; i++) do_fetch(vecs[i]);

    // Flush coincident with a response: data dropped, redirected PC used.
    pc = 64'h180; bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready = 0; bus.imem_resp_valid = 1; bus.imem_resp_data = 32'hdead_beef;
    flush = 1; pc = 64'h200;
    #1;
    check("flush+resp pc_advance", pc_advance, 0);
    tick();
    bus.imem_resp_valid = 0; flush = 0;
    #1;
    check("flush+resp if_valid", bus.if_valid, 0);
    check("flush+resp req_valid", bus.imem_req_valid, 1);
    check("flush+resp req_addr", bus.imem_req_addr, 64'h200);
    do_fetch('{64'h200, 0, 0, 0, 32'h0000_0513, 64'h200});

    // Flush in REQ before acceptance: address follows the new PC.
    pc = 64'h300;
    #1;
    check("req flush addr before", bus.imem_req_addr, 64'h300);
    flush = 1; pc = 64'h340;
    #1;
    check("req flush pc_advance", pc_advance, 0);
    tick();
    flush = 0;
    #1;
    check("req flush valid after", bus.imem_req_valid, 1);
    check("req flush addr after", bus.imem_req_addr, 64'h340);
    do_fetch('{64'h340, 0, 1, 0, 32'h0040_0293, 64'h340});

    // Flush in the same cycle as acceptance: the response is dropped.
    pc = 64'h700; bus.imem_req_ready = 1; flush = 1;
    #1;
    check("accept flush pc_advance", pc_advance, 0);
    tick();
    bus.imem_req_ready = 0; flush = 0; pc = 64'h800;
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h2222_2222;
    #1;
    check("accept flush resp pc_advance", pc_advance, 0);
    tick();
    bus.imem_resp_valid = 0;
    #1;
    check("accept flush if_valid", bus.if_valid, 0);
    check("accept flush req_valid", bus.imem_req_valid, 1);
    check("accept flush req_addr", bus.imem_req_addr, 64'h800);
    do_fetch('{64'h800, 0, 0, 0, 32'h0080_0313, 64'h800});

    // Flush in WAIT, response arrives later and is discarded.
    pc = 64'h900; bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready = 0; flush = 1; pc = 64'ha00;
    #1;
    check("wait flush pc_advance", pc_advance, 0);
    tick();
    flush = 0;
    #1;
    check("wait flush still waiting", bus.imem_req_valid, 0);
    tick();
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h3333_3333;
    #1;
    check("wait flush late pc_advance", pc_advance, 0);
    tick();
    bus.imem_resp_valid = 0;
    #1;
    check("wait flush if_valid", bus.if_valid, 0);
    check("wait flush req_valid", bus.imem_req_valid, 1);
    check("wait flush req_addr", bus.imem_req_addr, 64'ha00);

    // Flush in FULL with if_ready high: instruction is not consumed.
    pc = 64'ha00; bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready = 0; bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h1111_1111;
    sb.push_back('{32'h1111_1111, 64'ha00, 1'b0});
    #1;
    check("full flush resp pc_advance", pc_advance, 1);
    tick();
    bus.imem_resp_valid = 0;
    #1;
    check("full flush if_valid", bus.if_valid, 1);
    pop_compare("full flush");
    flush = 1; bus.if_ready = 1; pc = 64'h600;
    #1;
    check("full flush pc_advance", pc_advance, 0);
    tick();
    flush = 0; bus.if_ready = 0;
    #1;
    check("full flush drop valid", bus.if_valid, 0);
    check("full flush req_valid", bus.imem_req_valid, 1);
    check("full flush req_addr", bus.imem_req_addr, 64'h600);
    do_fetch('{64'h600, 0, 0, 0, 32'h0060_0393, 64'h600});

    // Asynchronous reset while in WAIT; a late response must be ignored.
    pc = 64'hb00; bus.imem_req_ready = 1;
    tick();
    bus.imem_req_ready = 0;
    #2;
    rst = 1;
    #1;
    check_reset_outputs("async reset");
    tick();
    rst = 0; bus.imem_resp_valid = 1; bus.imem_resp_data = 32'h4444_4444;
    #1;
    check("late resp idle pc_advance", pc_advance, 0);
    tick();
    check("late resp req pc_advance", pc_advance, 0);
    check("late resp req_valid", bus.imem_req_valid, 1);
    bus.imem_resp_valid = 0;
    tick();
    check("late resp if_valid", bus.if_valid, 0);
    check("late resp if_instr", bus.if_instr, 64'h13);
    do_fetch('{64'hb00, 0, 0, 0, 32'h00b0_0413, 64'hb00});

`ifdef IFETCH_MISALIGN_CHECK_EN
    pc = 64'h102;
    #1;
    check("misalign req_valid", bus.imem_req_valid, 0);
    check("misalign pc_advance", pc_advance, 1);
    sb.push_back('{32'h0000_0013, 64'h102, 1'b1});
    tick();
    pc = 64'h104;
    #1;
    check("misalign if_valid", bus.if_valid, 1);
    check("misalign req_valid full", bus.imem_req_valid, 0);
    pop_compare("misalign");
    bus.if_ready = 1;
    tick();
    bus.if_ready = 0;
    #1;
    check("misalign drain req_valid", bus.imem_req_valid, 1);
    do_fetch('{64'h104, 0, 0, 0, 32'h0010_0493, 64'h104});
`endif

    check("scoreboard empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and decode. Takes the current `pc` and issues one request at a time to instruction memory over a valid/ready handshake. Captures the 32-bit response into a one-entry output buffer and presents it to decode with its PC. Pulses `pc_advance` so the PC register loads its next value only when a fetch has actually completed.

## Interface
Parameters:
- `ADDR_W`, default 64: PC and memory address width.
- `INSTR_W`, default 32: instruction width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  ADDR_W  current PC from the program counter.
- `pc_advance`  out  1  one-cycle pulse; the PC register loads `pc_next` on the following edge.
- `flush`  in  1  redirect (taken branch); discards all in-flight work.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  ADDR_W  fetch address.
- `imem_resp_valid`  in  1  response data valid.
- `imem_resp_data`  in  INSTR_W  fetched instruction.
- `if_valid`  out  1  decode output valid.
- `if_ready`  in  1  decode accepts the instruction.
- `if_instr`  out  INSTR_W  instruction to decode.
- `if_pc`  out  ADDR_W  PC of `if_instr`.
- `if_fault`  out  1  misaligned fetch flag; tied 0 unless the macro below is defined.

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT`, `FULL`. One outstanding request at most.
- `IDLE`: entered only on reset. Moves to `REQ` on the next edge.
- `REQ`: drives `imem_req_valid=1` and `imem_req_addr=pc`.
  - On `imem_req_valid & imem_req_ready`, latches `pc` into `if_pc` and moves to `WAIT`.
  - Valid stays high with a stable address until accepted.
- `WAIT`: on `imem_resp_valid`, captures data into `if_instr`, asserts `pc_advance` for that cycle, and moves to `FULL`.
- `FULL`: holds `if_valid=1` with `if_instr`, `if_pc` and `if_fault` stable. On `if_ready`, moves to `REQ`.
- `flush` in `REQ`, before acceptance: stays in `REQ`; the address follows the new `pc` on the next cycle.
- `flush` in `REQ` in the same cycle as acceptance: the request counts as issued. Moves to `WAIT` with a drop flag set.
- `flush` in `WAIT`: sets the drop flag. The next response is discarded with no `pc_advance`, then the state moves to `REQ`.
- `flush` in `FULL`: `if_valid` drops on the next edge and the state moves to `REQ`. The instruction is treated as not consumed even if `if_ready` was high.
- Simultaneous `flush` and `imem_resp_valid` in `WAIT`: flush wins, the response is dropped and `pc_advance` stays 0.
- `pc_advance` is never asserted in a cycle where `flush=1`. The upstream redirect owns the PC that cycle.
- Responses arriving outside `WAIT` are ignored.

## Timing
- Reset values: state `IDLE`, `imem_req_valid=0`, `imem_req_addr=0`, `pc_advance=0`, `if_valid=0`, `if_instr=32'h0000_0013` (NOP), `if_pc=0`, `if_fault=0`, drop flag 0.
- Minimum loop, zero-wait memory:
  - Request accepted in cycle N.
  - Response in N+1, with `pc_advance` in N+1.
  - `if_valid` in N+2.
  - If `if_ready=1` in N+2, the next request is in N+3.
  - Best-case throughput is one instruction per 3 cycles.
- Every output is registered except `pc_advance` and `imem_req_addr`, which are combinational from state, `pc`, `flush` and `imem_resp_valid`.
- Reset asserted mid-operation clears everything at once. Any response from a request issued before reset is ignored.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - In `REQ`, if `pc[1:0]!=0`, no memory request is issued.
  - On the next edge the block enters `FULL` with `if_fault=1`, `if_instr=NOP` and `if_pc=pc`, and pulses `pc_advance` in the detecting cycle.
- Not defined: `imem_req_addr` is `{pc[ADDR_W-1:2],2'b00}` and `if_fault` is constant 0.

## Structure
- Shared package `riscv_pkg` holds:
  - the `ifetch_state_t` enum (`IDLE`, `REQ`, `WAIT`, `FULL`);
  - `INSTR_NOP = 32'h0000_0013`;
  - `IFETCH_ALIGN_BITS = 2`.
- One natural sub-module: `fetch_buffer`, the one-entry `if_instr`/`if_pc`/`if_fault` holding register with load, clear and valid. The FSM stays in `instruction_fetch`.

## Test plan
- Reset, then zero-wait memory with `pc=0x0`, `if_ready=1`: request at cycle 1, `pc_advance` at cycle 2, `if_valid` with `if_pc=0x0` at cycle 3.
- `imem_req_ready` held low 4 cycles with `pc=0x100`: `imem_req_valid` and address stay stable; no `pc_advance` until the response.
- `if_ready` low 5 cycles in `FULL`: `if_instr` and `if_pc` stable, no new request, then a request the cycle after `if_ready` rises.
- `flush` coincident with `imem_resp_valid` (data `0xDEADBEEF`): data never appears on `if_instr`, `pc_advance=0`, and the next request uses the redirected `pc=0x200`.
- Async `rst` pulse in `WAIT`: all outputs return to reset values immediately, and a late response is ignored.
- With `IFETCH_MISALIGN_CHECK_EN`, `pc=0x102`: no `imem_req_valid`; next cycle `if_valid=1`, `if_fault=1`, `if_instr=0x00000013`.
